// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the RV32I front-end sequencer.
// No logic of its own; consumed by pipe_front_ctrl and its testbench.
// Bubble contents and register-field positions are defined once here.
package rv32_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Register-address field positions inside an RV32I instruction word
  localparam int REG_W   = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } id_ex_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = 32'h0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b.valid = 1'b0;
    b.pc    = 32'h0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

  // Raw field extraction, no opcode qualification
  function automatic logic [REG_W-1:0] reg_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous active-low clear.
// Latency: count visible one cycle after an enabled edge.
// No backpressure; sticks at all-ones once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment unless already all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_front_ctrl.sv
// Front-end sequencer: PC, IF/ID and ID/EX registers with stall/flush handling.
// Latency: fetch accepted at edge N is in IF/ID after N, in ID/EX after N+1.
// Backpressure: imem_ready=0 inserts IF/ID bubbles; stall freezes PC and both registers.
module pipe_front_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      branch_target,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             id_ex_valid,
  output logic [31:0]      id_ex_pc,
  output logic [31:0]      id_ex_instr,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  logic        stall_inc, flush_inc;

  // Next-state, register updates and handshake outputs; stall beats flush beats normal
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_id_d   = if_id_q;
    id_ex_d   = id_ex_q;
    imem_req  = 1'b0;
    ex_bubble = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          ex_bubble = 1'b1;
          stall_inc = 1'b1;
        end else if (flush) begin
          // Any fetch returned this cycle belongs to the wrong path
          imem_req  = 1'b1;
          pc_d      = branch_target;
          if_id_d   = if_id_bubble();
          id_ex_d   = id_ex_bubble();
          flush_inc = 1'b1;
        end else begin
          imem_req = 1'b1;
          id_ex_d  = '{valid: if_id_q.valid, pc: if_id_q.pc, instr: if_id_q.instr};
          if (imem_ready) begin
            pc_d    = pc_q + 32'd4;
            if_id_d = '{valid: 1'b1, pc: pc_q, instr: imem_instr};
          end else begin
            if_id_d = if_id_bubble();
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      if_id_q <= if_id_bubble();
      id_ex_q <= id_ex_bubble();
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      id_ex_q <= id_ex_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rstn),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rstn),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

  assign pc          = pc_q;
  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign id_ex_valid = id_ex_q.valid;
  assign id_ex_pc    = id_ex_q.pc;
  assign id_ex_instr = id_ex_q.instr;

  // Bubbles report zero register fields so hazard/forwarding never matches them
  assign id_ex_rs1 = id_ex_q.valid ? reg_field(id_ex_q.instr, RS1_LSB) : 5'd0;
  assign id_ex_rs2 = id_ex_q.valid ? reg_field(id_ex_q.instr, RS2_LSB) : 5'd0;
  assign id_ex_rd  = id_ex_q.valid ? reg_field(id_ex_q.instr, RD_LSB)  : 5'd0;

endmodule

// File: doc/pipe_front_ctrl.md
# pipe_front_ctrl

Front-end pipeline sequencer for the RV32I five-stage core: owns the PC, IF/ID and ID/EX registers and applies the `stall`/`flush` commands issued by the hazard detection unit. It fetches through a ready-handshaked instruction port, inserts NOP bubbles, and redirects the PC on taken branches. It presents the ID/EX register-address fields consumed by hazard detection and forwarding, and it counts applied stalls and flushes for the simulator's statistics dump.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CNT_W`, 16, width of the stall and flush counters
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous active-low reset
- `stall` in 1: load-use stall from hazard detection
- `flush` in 1: control-hazard flush from hazard detection
- `branch_target` in 32: redirect PC, sampled when a flush is applied
- `imem_req` out 1: fetch request at `pc`
- `imem_ready` in 1: `imem_instr` valid this cycle for `pc`
- `imem_instr` in 32: fetched instruction
- `pc` out 32: current fetch address
- `if_id_valid`, `if_id_pc`[32], `if_id_instr`[32] out: IF/ID register
- `id_ex_valid`, `id_ex_pc`[32], `id_ex_instr`[32] out: ID/EX register
- `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd` out 5 each: ID/EX register-address fields
- `ex_bubble` out 1: the EX/MEM register must load a bubble next edge
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters

## Operation
- FSM with two states, BOOT and RUN. Reset enters BOOT. BOOT lasts one cycle with `imem_req`=0 and no register updates, then goes to RUN. RUN has no exit except reset.
- Command priority in RUN: stall > flush > normal. Simultaneous stall and flush means stall is applied, the flush is dropped, and flush_cnt does not count it.
- Stall:
  - PC, IF/ID and ID/EX hold.
  - `ex_bubble`=1.
  - `imem_req`=0.
  - stall_cnt increments.
- Flush:
  - PC loads `branch_target`.
  - IF/ID and ID/EX load bubbles.
  - flush_cnt increments.
  - Any fetch this cycle is discarded.
- Normal with `imem_ready`=1:
  - PC advances by 4.
  - IF/ID loads {1, pc, imem_instr}.
  - ID/EX loads IF/ID.
- Normal with `imem_ready`=0:
  - PC holds.
  - IF/ID loads a bubble.
  - ID/EX loads IF/ID.
- Bubble: valid=0, instr=32'h0000_0013, pc=0, rs1=rs2=rd=0. Zero fields guarantee no false forwarding or hazard match.
- Field extraction when ID/EX loads a valid instruction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]. Extraction is raw, with no opcode filtering.
- `imem_req`=1 in RUN whenever stall=0.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Counters saturate at all-ones.

## Timing
- Reset values (asynchronous, immediate on `rstn`=0):
  - `pc`=RESET_PC.
  - Both valids are 0, and both registers hold bubble contents.
  - `ex_bubble`=0, `imem_req`=0.
  - Both counters are 0.
  - State is BOOT.
- First fetch request occurs in the second cycle after `rstn` rises.
- Latency: an instruction accepted at edge N appears in IF/ID after N, and in ID/EX after N+1 (absent stall or flush).
- `ex_bubble` is combinational from `stall` in RUN and is 0 in BOOT.
- Commands are sampled at the rising edge; their effects are visible after that edge.
- Reset asserted mid-stall or mid-flush: everything returns to reset values, counters included.

## Structure
- Shared package `rv32_pipe_pkg` holds:
  - `NOP_INSTR` (32'h0000_0013).
  - The field bit positions for rs1, rs2 and rd.
  - The FSM state enum.
  - The IF/ID and ID/EX struct typedefs, each with valid, pc and instr fields.
- One sub-module, `sat_counter` (width parameter, increment enable, asynchronous active-low clear), instantiated twice.

## Test plan
- Reset behaviour: release reset with RESET_PC=32'h100 and `imem_ready`=1. Required response:
  - `imem_req` is 0 for one cycle, then 1.
  - After 3 fetches: pc=0x10C, if_id_pc=0x108, id_ex_pc=0x104.
- Load-use stall: with id_ex_instr=32'h00208033 (add x0,x1,x2), assert `stall` for 1 cycle. Required response:
  - pc, IF/ID and ID/EX hold.
  - `ex_bubble`=1 for exactly that cycle.
  - stall_cnt goes 0→1.
  - id_ex_rs1=1 and id_ex_rs2=2 persist.
- Flush: with pc=0x200, assert `flush` and branch_target=0x80. Required response:
  - Next cycle pc=0x80, both valids 0, id_ex_rs1=rs2=rd=0.
  - flush_cnt=1.
  - The following fetch loads if_id_pc=0x80.
- Simultaneous stall and flush: required response:
  - Stall behaviour is applied.
  - pc does not load branch_target.
  - flush_cnt is unchanged.
- Memory wait: hold `imem_ready`=0 for 2 cycles at pc=0x40. Required response:
  - pc stays 0x40.
  - Two bubbles enter IF/ID, then ID/EX.
  - Fetch resumes at 0x40.
- PC wrap and counter saturation:
  - pc=0xFFFF_FFFC with a normal fetch gives pc=0.
  - With CNT_W=2, four stalls leave stall_cnt=3.
  - Reset mid-stall clears stall_cnt to 0 immediately.
